axi4_lite_mem_slave: RTL and testbench
======================================

AXI4_LITE_MEM_SLAVE -- requirements
Module: axi4_lite_mem_slave

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width; legal values 32, 64.
REQ-003 SHALL have parameter DATA_DEPTH, default 32, number of DATA_WIDTH-bit words; any value >= 2.
REQ-004 SHALL have ports ACLK in 1, sole clock (rising edge); ARESETN in 1, asynchronous active-low reset.
REQ-005 SHALL have ports S_AXI_AWADDR in ADDRESS_WIDTH; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1: write address channel.
REQ-006 SHALL have ports S_AXI_WDATA in DATA_WIDTH; S_AXI_WSTRB in DATA_WIDTH/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1: write data channel.
REQ-007 SHALL have ports S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1: write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in ADDRESS_WIDTH; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1: read address channel.
REQ-009 SHALL have ports S_AXI_RDATA out DATA_WIDTH; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1: read data channel.

Function
REQ-010 SHALL decode word index = ADDR >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
REQ-011 SHALL treat word index >= DATA_DEPTH as out-of-range: response SLVERR (2'b10), memory untouched, RDATA = 0.
REQ-012 SHALL respond OKAY (2'b00) for in-range accesses; DECERR never generated.
REQ-013 SHALL run read and write paths as independent FSMs; read and write SHALL proceed concurrently.
REQ-014 Write FSM SHALL have states W_IDLE, W_ADDR (AW held), W_DATA (W held), W_RESP.
REQ-015 SHALL accept AW and W in either order or the same cycle; each captured into its own holding register on handshake.
REQ-016 AWREADY SHALL be 1 only in W_IDLE and W_DATA; WREADY SHALL be 1 only in W_IDLE and W_ADDR (combinational from state).
REQ-017 On the edge at which both address and data are held, SHALL commit the write and enter W_RESP with BVALID=1 the next cycle (1-cycle latency from the later handshake).
REQ-018 Write commit SHALL update only byte lanes whose WSTRB bit is 1; WSTRB = 0 SHALL yield OKAY with no change.
REQ-019 BVALID/BRESP SHALL hold stable until BREADY=1; W_RESP -> W_IDLE on that edge; no new AW/W accepted while in W_RESP.
REQ-020 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY = 1 only in R_IDLE.
REQ-021 On AR handshake SHALL register RDATA/RRESP and enter R_DATA, RVALID=1 the next cycle (1-cycle latency).
REQ-022 RDATA/RRESP SHALL hold stable while RVALID=1 and RREADY=0; R_DATA -> R_IDLE on RREADY=1.
REQ-023 Read captured on the same edge as a write commit to the same word SHALL return pre-write data.
REQ-024 Sustained throughput SHALL be one read per 2 cycles and one write per 2 cycles with RREADY/BREADY held 1.
REQ-025 SHALL never assert RVALID or BVALID without a prior accepted request; VALID inputs dropping without handshake SHALL be ignored.

Reset
REQ-026 ARESETN=0 SHALL immediately: both FSMs to IDLE, all memory words and holding registers to 0, BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0, AWREADY=WREADY=ARREADY=1.
REQ-027 Reset mid-transaction SHALL discard pending AW/W/AR and responses with no partial memory write.
REQ-028 First handshake SHALL be accepted on the first rising edge after ARESETN deasserts.

Verification
REQ-029 Write AWADDR=0x08, WDATA=0xDEADBEEF, WSTRB=0xF same cycle, BREADY=1 -> BVALID next cycle, BRESP=00; read 0x08 -> RDATA=0xDEADBEEF, RRESP=00.
REQ-030 W first (0x11223344), AW=0x04 three cycles later -> WREADY=0 meanwhile, BVALID 1 cycle after AW handshake; then WSTRB=0x2, WDATA=0x0000AA00 -> read 0x04 returns 0x1122AA44.
REQ-031 AWADDR=DATA_DEPTH*4 (0x80 default) -> BRESP=10, all words unchanged; ARADDR=0x80 -> RRESP=10, RDATA=0.
REQ-032 Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/RVALID, BRESP/RRESP/RDATA stable; AWREADY=WREADY=ARREADY=0 throughout.
REQ-033 Concurrent write 0x55 to 0x0C and read of 0x0C captured on the commit edge -> RDATA=old value (0); following read returns 0x55.
REQ-034 Assert ARESETN=0 with AW held and RVALID=1 -> outputs per REQ-026 immediately; after release read 0x08 returns 0.

Source files
------------

// File: rtl/axi4_lite_mem_slave_if.sv
// AXI4-Lite bus bundle for axi4_lite_mem_slave.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R) under their original
// S_AXI_* names. The master modport drives requests and ready-for-response
// signals; the slave modport drives the ready-for-request and response signals.
interface axi4_lite_mem_slave_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR;
   logic                      S_AXI_AWVALID;
   logic                      S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
   logic                      S_AXI_WVALID;
   logic                      S_AXI_WREADY;
   logic [1:0]                S_AXI_BRESP;
   logic                      S_AXI_BVALID;
   logic                      S_AXI_BREADY;
   logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR;
   logic                      S_AXI_ARVALID;
   logic                      S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
   logic [1:0]                S_AXI_RRESP;
   logic                      S_AXI_RVALID;
   logic                      S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite memory slave: DATA_DEPTH words of DATA_WIDTH bits, byte-strobed
// writes, independent read and write state machines.
// Ports:
//   ACLK    - sole clock, rising edge
//   ARESETN - asynchronous active-low reset (clears memory and both FSMs)
//   s_axi   - AXI4-Lite slave modport (AW, W, B, AR, R channels)
// Word index = address >> log2(DATA_WIDTH/8). Indices >= DATA_DEPTH answer
// SLVERR, leave memory untouched and read back zero; all else is OKAY.
module axi4_lite_mem_slave #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DATA_DEPTH    = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   axi4_lite_mem_slave_if.slave  s_axi
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFFS   = $clog2(STRB_W);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   w_state_t                 w_state_q, w_state_d;
   r_state_t                 r_state_q, r_state_d;
   logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [STRB_W-1:0]        wstrb_q, wstrb_d;
   logic [1:0]               bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic [1:0]               rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]    mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0]    mem_d [DATA_DEPTH];

   logic                     commit;
   logic [ADDRESS_WIDTH-1:0] cm_addr, cm_idx;
   logic [DATA_WIDTH-1:0]    cm_data;
   logic [STRB_W-1:0]        cm_strb;
   logic [ADDRESS_WIDTH-1:0] ar_idx;

   // Write path. The commit always happens on the edge of the later
   // handshake, using the live bus value for whichever half arrives then
   // and the holding register for the half that arrived earlier.
   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      mem_d     = mem_q;
      commit    = 1'b0;
      cm_addr   = awaddr_q;
      cm_data   = wdata_q;
      cm_strb   = wstrb_q;
      case (w_state_q)
         W_IDLE: begin
            if (s_axi.S_AXI_AWVALID) awaddr_d = s_axi.S_AXI_AWADDR;
            if (s_axi.S_AXI_WVALID) begin
               wdata_d = s_axi.S_AXI_WDATA;
               wstrb_d = s_axi.S_AXI_WSTRB;
            end
            if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
               commit    = 1'b1;
               cm_addr   = s_axi.S_AXI_AWADDR;
               cm_data   = s_axi.S_AXI_WDATA;
               cm_strb   = s_axi.S_AXI_WSTRB;
               w_state_d = W_RESP;
            end else if (s_axi.S_AXI_AWVALID) begin
               w_state_d = W_ADDR;
            end else if (s_axi.S_AXI_WVALID) begin
               w_state_d = W_DATA;
            end
         end
         W_ADDR: begin
            if (s_axi.S_AXI_WVALID) begin
               wdata_d   = s_axi.S_AXI_WDATA;
               wstrb_d   = s_axi.S_AXI_WSTRB;
               commit    = 1'b1;
               cm_data   = s_axi.S_AXI_WDATA;
               cm_strb   = s_axi.S_AXI_WSTRB;
               w_state_d = W_RESP;
            end
         end
         W_DATA: begin
            if (s_axi.S_AXI_AWVALID) begin
               awaddr_d  = s_axi.S_AXI_AWADDR;
               commit    = 1'b1;
               cm_addr   = s_axi.S_AXI_AWADDR;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase

      // An address matching no word is out of range: SLVERR, no update.
      cm_idx = cm_addr >> OFFS;
      if (commit) begin
         bresp_d = RESP_SLVERR;
         for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
            if (cm_idx == ADDRESS_WIDTH'(i)) begin
               bresp_d = RESP_OKAY;
               for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (cm_strb[b]) mem_d[i][b*8 +: 8] = cm_data[b*8 +: 8];
               end
            end
         end
      end
   end

   // Read path. Data is taken from mem_q, so a read captured on a commit
   // edge sees the pre-write contents.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      ar_idx    = s_axi.S_AXI_ARADDR >> OFFS;
      case (r_state_q)
         R_IDLE: begin
            if (s_axi.S_AXI_ARVALID) begin
               r_state_d = R_DATA;
               rdata_d   = '0;
               rresp_d   = RESP_SLVERR;
               for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
                  if (ar_idx == ADDRESS_WIDTH'(i)) begin
                     rdata_d = mem_q[i];
                     rresp_d = RESP_OKAY;
                  end
               end
            end
         end
         R_DATA: begin
            if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         for (int unsigned i = 0; i < DATA_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         mem_q     <= mem_d;
      end
   end

   assign s_axi.S_AXI_AWREADY = (w_state_q == W_IDLE) || (w_state_q == W_DATA);
   assign s_axi.S_AXI_WREADY  = (w_state_q == W_IDLE) || (w_state_q == W_ADDR);
   assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = (r_state_q == R_IDLE);
   assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Self-checking bench for axi4_lite_mem_slave (default parameters).
// Directed vectors for the documented scenarios plus randomized reads and
// writes, compared against a word-array reference model.
module tb_axi4_lite_mem_slave;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 32;

   logic aclk;
   logic aresetn;
   int   checks;
   int   failures;

   logic [31:0] model [DEPTH];

   axi4_lite_mem_slave_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi4_lite_mem_slave #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .DATA_DEPTH   (DEPTH)
   ) dut (
      .ACLK   (aclk),
      .ARESETN(aresetn),
      .s_axi  (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input logic [31:0] addr);
      return (addr >> 2) < DEPTH;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      logic [31:0] idx;
      idx = addr >> 2;
      if (idx < DEPTH) return model[idx];
      return 32'h0;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      logic [31:0] idx;
      logic [31:0] word;
      idx = addr >> 2;
      if (idx < DEPTH) begin
         word = model[idx];
         for (int b = 0; b < 4; b++)
            if (strb[b]) word[b*8 +: 8] = data[b*8 +: 8];
         model[idx] = word;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bvalid"},  bus.S_AXI_BVALID, 1'b0);
      check({tag, "_rvalid"},  bus.S_AXI_RVALID, 1'b0);
      check({tag, "_bresp"},   bus.S_AXI_BRESP, 2'b00);
      check({tag, "_rresp"},   bus.S_AXI_RRESP, 2'b00);
      check({tag, "_rdata"},   bus.S_AXI_RDATA, 32'h0);
      check({tag, "_awready"}, bus.S_AXI_AWREADY, 1'b1);
      check({tag, "_wready"},  bus.S_AXI_WREADY, 1'b1);
      check({tag, "_arready"}, bus.S_AXI_ARREADY, 1'b1);
   endtask

   // AW is offered from cycle aw_dly, W from cycle w_dly (relative to start).
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
      bit aw_done;
      bit w_done;
      int cyc;
      aw_done = 1'b0;
      w_done  = 1'b0;
      cyc     = 0;
      bus.S_AXI_BREADY = 1'b1;
      while (!(aw_done && w_done) && cyc < 16) begin
         @(negedge aclk);
         if (aw_done && !w_done) check("awready_while_aw_held", bus.S_AXI_AWREADY, 1'b0);
         if (w_done && !aw_done) check("wready_while_w_held", bus.S_AXI_WREADY, 1'b0);
         check("bvalid_before_handshake", bus.S_AXI_BVALID, 1'b0);
         bus.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
         bus.S_AXI_AWADDR  = addr;
         bus.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
         bus.S_AXI_WDATA   = data;
         bus.S_AXI_WSTRB   = strb;
         if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_done = 1'b1;
         if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_done = 1'b1;
         cyc++;
      end
      check("write_handshakes_done", {aw_done, w_done}, 2'b11);
      @(negedge aclk);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      check("bvalid_latency", bus.S_AXI_BVALID, 1'b1);
      check("bresp", bus.S_AXI_BRESP, in_range(addr) ? 2'b00 : 2'b10);
      model_write(addr, data, strb);
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] got_data,
                          output logic [1:0] got_resp);
      @(negedge aclk);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY  = 1'b1;
      check("arready_idle", bus.S_AXI_ARREADY, 1'b1);
      @(negedge aclk);
      bus.S_AXI_ARVALID = 1'b0;
      check("rvalid_latency", bus.S_AXI_RVALID, 1'b1);
      check("rdata", bus.S_AXI_RDATA, model_read(addr));
      check("rresp", bus.S_AXI_RRESP, in_range(addr) ? 2'b00 : 2'b10);
      got_data = bus.S_AXI_RDATA;
      got_resp = bus.S_AXI_RRESP;
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rr;
      logic [31:0] exp_rdata;
      logic [31:0] addr;
      checks   = 0;
      failures = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      bus.S_AXI_AWADDR  = '0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA   = '0;
      bus.S_AXI_WSTRB   = '0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b1;
      bus.S_AXI_ARADDR  = '0;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b1;
      aresetn = 1'b1;
      #2 aresetn = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;

      // Memory starts cleared.
      do_read(32'h0000_0000, rd, rr);
      do_read(32'h0000_007C, rd, rr);

      // Same-cycle AW/W write then readback.
      do_write(32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0);
      do_read(32'h08, rd, rr);
      check("req029_rdata", rd, 32'hDEAD_BEEF);
      check("req029_rresp", rr, 2'b00);

      // W leads AW by three cycles, then a single-lane update.
      do_write(32'h04, 32'h1122_3344, 4'hF, 3, 0);
      do_write(32'h04, 32'h0000_AA00, 4'h2, 0, 0);
      do_read(32'h04, rd, rr);
      check("req030_rdata", rd, 32'h1122_AA44);

      // AW leads W, zero strobe leaves the word alone.
      do_write(32'h06, 32'hFFFF_FFFF, 4'h0, 0, 2);
      do_read(32'h04, rd, rr);
      check("strb0_rdata", rd, 32'h1122_AA44);

      // Out-of-range write and read.
      do_write(32'h80, 32'hCAFE_F00D, 4'hF, 0, 0);
      for (int i = 0; i < DEPTH; i++) do_read(32'(i * 4), rd, rr);
      do_read(32'h80, rd, rr);
      check("req031_rresp", rr, 2'b10);
      check("req031_rdata", rd, 32'h0);

      // Concurrent write and read of 0x0C on the same edge.
      @(negedge aclk);
      bus.S_AXI_AWADDR  = 32'h0C;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = 32'h55;
      bus.S_AXI_WSTRB   = 4'hF;
      bus.S_AXI_WVALID  = 1'b1;
      bus.S_AXI_ARADDR  = 32'h0C;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_BREADY  = 1'b1;
      bus.S_AXI_RREADY  = 1'b1;
      exp_rdata = model_read(32'h0C);
      @(negedge aclk);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_ARVALID = 1'b0;
      check("req033_bvalid", bus.S_AXI_BVALID, 1'b1);
      check("req033_rvalid", bus.S_AXI_RVALID, 1'b1);
      check("req033_old_model", bus.S_AXI_RDATA, exp_rdata);
      check("req033_old_zero", bus.S_AXI_RDATA, 32'h0);
      model_write(32'h0C, 32'h55, 4'hF);
      do_read(32'h0C, rd, rr);
      check("req033_new", rd, 32'h55);

      // Back-pressure: responses held stable, no new requests accepted.
      @(negedge aclk);
      bus.S_AXI_AWADDR  = 32'h10;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = 32'h0BAD_CAFE;
      bus.S_AXI_WSTRB   = 4'hF;
      bus.S_AXI_WVALID  = 1'b1;
      bus.S_AXI_ARADDR  = 32'h08;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_BREADY  = 1'b0;
      bus.S_AXI_RREADY  = 1'b0;
      exp_rdata = model_read(32'h08);
      @(negedge aclk);
      bus.S_AXI_AWADDR  = 32'h14;
      bus.S_AXI_ARADDR  = 32'h04;
      for (int c = 0; c < 5; c++) begin
         check("stall_bvalid", bus.S_AXI_BVALID, 1'b1);
         check("stall_bresp", bus.S_AXI_BRESP, 2'b00);
         check("stall_rvalid", bus.S_AXI_RVALID, 1'b1);
         check("stall_rdata", bus.S_AXI_RDATA, exp_rdata);
         check("stall_rresp", bus.S_AXI_RRESP, 2'b00);
         check("stall_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
         @(negedge aclk);
      end
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_BREADY  = 1'b1;
      bus.S_AXI_RREADY  = 1'b1;
      model_write(32'h10, 32'h0BAD_CAFE, 4'hF);
      @(negedge aclk);
      check("stall_release_bvalid", bus.S_AXI_BVALID, 1'b0);
      check("stall_release_rvalid", bus.S_AXI_RVALID, 1'b0);
      do_read(32'h10, rd, rr);
      do_read(32'h14, rd, rr);

      // Randomized mix, including out-of-range words and byte offsets.
      for (int n = 0; n < 120; n++) begin
         addr = 32'($urandom_range(0, DEPTH + 3) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else
            do_read(addr, rd, rr);
      end
      for (int i = 0; i < DEPTH; i++) do_read(32'(i * 4), rd, rr);

      // Reset with AW held and a read response pending.
      do_write(32'h08, 32'h1234_5678, 4'hF, 0, 0);
      @(negedge aclk);
      bus.S_AXI_AWADDR  = 32'h08;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_ARADDR  = 32'h08;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY  = 1'b0;
      @(negedge aclk);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_ARVALID = 1'b0;
      check("pre_reset_rvalid", bus.S_AXI_RVALID, 1'b1);
      check("pre_reset_wready_only", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b01);
      #1 aresetn = 1'b0;
      #1 check_reset_outputs("midreset");
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      @(negedge aclk);
      aresetn = 1'b1;
      bus.S_AXI_RREADY = 1'b1;
      do_read(32'h08, rd, rr);
      check("req034_rdata", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
